// File: rtl/load_select_pkg.sv
// rtl/load_select_pkg.sv - opcodes, size codes, FSM states and helpers shared by the load unit
package load_select_pkg;

  // Load opcodes of the MEM-stage instruction
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LW  = 6'b100011;

  // data_size encodings on the memory request
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } loadState_t;

  // Access size of a load opcode; anything unrecognised is treated as a word
  function automatic logic [1:0] sizeOf(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU: return SIZE_B;
      OP_LH, OP_LHU: return SIZE_H;
      default:       return SIZE_W;
    endcase
  endfunction

  // True when the byte offset is not naturally aligned for the access size
  function automatic logic isMisaligned(input logic [5:0] op, input logic [1:0] off);
    case (op)
      OP_LH, OP_LHU: return off[0];
      OP_LW:         return off != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// rtl/load_extract.sv - selects and extends the addressed byte/halfword/word of a read word
module load_extract
  import load_select_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Pick the lane by offset (little-endian), then extend according to the opcode
  always_comb begin
    byteSel = rdata[7:0];
    case (off)
      2'd0: byteSel = rdata[7:0];
      2'd1: byteSel = rdata[15:8];
      2'd2: byteSel = rdata[23:16];
      2'd3: byteSel = rdata[31:24];
      default: byteSel = rdata[7:0];
    endcase
    halfSel = off[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   result = {{24{byteSel[7]}}, byteSel};
      OP_LBU:  result = {24'd0, byteSel};
      OP_LH:   result = {{16{halfSel[15]}}, halfSel};
      OP_LHU:  result = {16'd0, halfSel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_select.sv
// rtl/load_select.sv - MEM-stage load unit: one read per load, extraction, stall and flush handling
module load_select
  import load_select_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        load_validM,
  input  logic [5:0]  opM,
  input  logic [31:0] addressM,
  input  logic        flushM,
  input  logic        advanceM,
  output logic        data_req,
  output logic [31:0] data_addr,
  output logic [1:0]  data_size,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        adelM,
  output logic [31:0] readdataM,
  output logic        stallM
);

  loadState_t  state, stateNext;
  logic [5:0]  opLatched;
  logic [1:0]  offLatched;
  logic [31:0] extracted;
  logic        accept;

  assign adelM  = load_validM & isMisaligned(opM, addressM[1:0]);
  assign accept = load_validM & ~adelM & ~flushM;
  assign stallM = (state == S_REQ) | (state == S_WAIT) | (state == S_DRAIN) |
                  ((state == S_IDLE) & accept);

  load_extract u_extract (
    .op     (opLatched),
    .off    (offLatched),
    .rdata  (data_rdata),
    .result (extracted)
  );

  // Next-state: a flush either withdraws an unaccepted request or drains an accepted one
  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (accept) stateNext = S_REQ;
      S_REQ: begin
        if (flushM)            stateNext = data_addr_ok ? S_DRAIN : S_IDLE;
        else if (data_addr_ok) stateNext = S_WAIT;
      end
      S_WAIT: begin
        if (flushM)            stateNext = data_data_ok ? S_IDLE : S_DRAIN;
        else if (data_data_ok) stateNext = S_DONE;
      end
      S_DONE:  if (advanceM | flushM) stateNext = S_IDLE;
      S_DRAIN: if (data_data_ok) stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= stateNext;
  end

  // Request registers: captured once on acceptance so they stay stable while data_req is high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_req   <= 1'b0;
      data_addr  <= 32'd0;
      data_size  <= SIZE_B;
      opLatched  <= 6'd0;
      offLatched <= 2'd0;
    end else begin
      data_req <= (stateNext == S_REQ);
      if ((state == S_IDLE) && accept) begin
        opLatched  <= opM;
        offLatched <= addressM[1:0];
        data_addr  <= {addressM[31:2], 2'b00};
        data_size  <= sizeOf(opM);
      end
    end
  end

  // Result register: only a non-flushed WAIT->DONE transition updates it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                            readdataM <= 32'd0;
    else if ((state == S_WAIT) && data_data_ok && !flushM) readdataM <= extracted;
  end

endmodule
